// File: rtl/peak_to_dds_cfg.sv
// peak_to_dds_cfg
//   Turns a find-max peak (bin index + three neighbour magnitudes) and a root
//   magnitude into one DDS phase-increment config beat and a 16-bit amplitude.
//   The bin position is refined by a 3-point centroid offset
//   |m2-m0| / (m0+m1+m2), computed by a bit-serial restoring divider.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   s_peak_tvalid/taddr/tdata_*  peak bin index and magnitudes of bins
//                                taddr-1, taddr, taddr+1 (signed)
//   s_root_tvalid/tdata          unsigned root magnitude
//   m_cfg_tvalid/tdata           DDS config beat {4'b0, pinc[27:0]}
//   amp_word, amp_valid          amplitude word (held), pulses with the beat
//   busy                         frame in progress
//   timeout_err                  pulse when a peak's root never arrives
module peak_to_dds_cfg #(
  parameter int          DATA_WIDTH     = 24,
  parameter int          ADDR_WIDTH     = 8,
  parameter int          ROOT_WIDTH     = 25,
  parameter int          FRAC_BITS      = 8,
  parameter int unsigned FREQ_K         = 4096,
  parameter int unsigned AMP_K          = 3,
  parameter int          AMP_SHIFT      = 2,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_peak_tvalid,
  input  logic [ADDR_WIDTH-1:0]        s_peak_taddr,
  input  logic signed [DATA_WIDTH-1:0] s_peak_tdata_0,
  input  logic signed [DATA_WIDTH-1:0] s_peak_tdata_1,
  input  logic signed [DATA_WIDTH-1:0] s_peak_tdata_2,
  input  logic                         s_root_tvalid,
  input  logic [ROOT_WIDTH-1:0]        s_root_tdata,
  output logic                         m_cfg_tvalid,
  output logic [31:0]                  m_cfg_tdata,
  output logic [15:0]                  amp_word,
  output logic                         amp_valid,
  output logic                         busy,
  output logic                         timeout_err
);

  // Remainder/denominator width: den < 3*2^(DW-1) and the shifted remainder
  // can reach 2*den, so two extra bits cover both without overflow.
  localparam int RW  = DATA_WIDTH + 2;
  localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int DCW = (FRAC_BITS > 1) ? $clog2(FRAC_BITS) : 1;
  localparam int PW  = ADDR_WIDTH + FRAC_BITS + 1;   // signed position
  localparam int MW  = PW - 1 + 32;                  // pos * FREQ_K
  localparam int AW  = ROOT_WIDTH + 32;              // root * AMP_K

  typedef enum logic [2:0] {IDLE, WAIT_ROOT, DIV, CALC, EMIT} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] m0_r, m1_r, m2_r;
  logic [ROOT_WIDTH-1:0] root_r;
  logic [RW-1:0]         rem_r, den_r;
  logic [FRAC_BITS-1:0]  q_r;
  logic                  neg_r;
  logic [DCW-1:0]        div_cnt;
  logic [TW-1:0]         to_cnt;
  logic [27:0]           pinc_r;
  logic [15:0]           amp_r;

  function automatic logic [DATA_WIDTH-1:0] clamp0(input logic signed [DATA_WIDTH-1:0] v);
    return v[DATA_WIDTH-1] ? '0 : v;
  endfunction

  // Magnitudes that will be in effect once this cycle's capture lands, so a
  // peak and root arriving together seed the divider with the new peak.
  logic [DATA_WIDTH-1:0] c0, c1, c2, n0, n1, n2;
  logic [RW-1:0]         num_nxt, den_nxt;

  always_comb begin
    c0 = clamp0(s_peak_tdata_0);
    c1 = clamp0(s_peak_tdata_1);
    c2 = clamp0(s_peak_tdata_2);
    n0 = s_peak_tvalid ? c0 : m0_r;
    n1 = s_peak_tvalid ? c1 : m1_r;
    n2 = s_peak_tvalid ? c2 : m2_r;
    num_nxt = (n2 >= n0) ? RW'(n2 - n0) : RW'(n0 - n2);
    den_nxt = RW'(n0) + RW'(n1) + RW'(n2);
  end

  // One restoring step; a zero denominator never produces a quotient bit.
  logic [RW-1:0] rem_sh;
  logic          q_bit;

  always_comb begin
    rem_sh = {rem_r[RW-2:0], 1'b0};
    q_bit  = (den_r != '0) && (rem_sh >= den_r);
  end

  // Position -> phase increment, root -> amplitude, both full precision
  // before saturation.
  logic signed [PW-1:0] pos_base, pos_q, pos_s;
  logic [PW-2:0]        pos_u;
  logic [MW-1:0]        pinc_prod, pinc_shr;
  logic [AW-1:0]        amp_prod, amp_shr;
  logic [27:0]          pinc_sat;
  logic [15:0]          amp_sat;

  always_comb begin
    pos_base  = $signed({1'b0, addr_r, {FRAC_BITS{1'b0}}});
    pos_q     = $signed({{(PW-FRAC_BITS){1'b0}}, q_r});
    pos_s     = neg_r ? (pos_base - pos_q) : (pos_base + pos_q);
    pos_u     = pos_s[PW-1] ? '0 : pos_s[PW-2:0];
    pinc_prod = MW'(pos_u) * MW'(FREQ_K);
    pinc_shr  = pinc_prod >> FRAC_BITS;
    pinc_sat  = (pinc_shr > MW'(28'hFFF_FFFF)) ? 28'hFFF_FFFF : pinc_shr[27:0];
    amp_prod  = AW'(root_r) * AW'(AMP_K);
    amp_shr   = amp_prod >> AMP_SHIFT;
    amp_sat   = (amp_shr > AW'(16'hFFFF)) ? 16'hFFFF : amp_shr[15:0];
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      addr_r       <= '0;
      m0_r         <= '0;
      m1_r         <= '0;
      m2_r         <= '0;
      root_r       <= '0;
      rem_r        <= '0;
      den_r        <= '0;
      q_r          <= '0;
      neg_r        <= 1'b0;
      div_cnt      <= '0;
      to_cnt       <= '0;
      pinc_r       <= '0;
      amp_r        <= '0;
      m_cfg_tvalid <= 1'b0;
      m_cfg_tdata  <= '0;
      amp_word     <= '0;
      amp_valid    <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      m_cfg_tvalid <= 1'b0;
      amp_valid    <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        IDLE, WAIT_ROOT: begin
          if (s_peak_tvalid) begin
            addr_r <= s_peak_taddr;
            m0_r   <= c0;
            m1_r   <= c1;
            m2_r   <= c2;
            to_cnt <= '0;
          end else if (state == WAIT_ROOT) begin
            to_cnt <= to_cnt + 1'b1;
          end
          // A root only counts once a peak is held or arriving with it.
          if (s_root_tvalid && (s_peak_tvalid || state == WAIT_ROOT)) begin
            root_r  <= s_root_tdata;
            rem_r   <= num_nxt;
            den_r   <= den_nxt;
            neg_r   <= (n2 < n0);
            q_r     <= '0;
            div_cnt <= '0;
            state   <= DIV;
          end else if (s_peak_tvalid) begin
            state <= WAIT_ROOT;
          end else if (state == WAIT_ROOT && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end
        DIV: begin
          rem_r   <= q_bit ? (rem_sh - den_r) : rem_sh;
          q_r     <= {q_r[FRAC_BITS-2:0], q_bit};
          div_cnt <= div_cnt + 1'b1;
          if (div_cnt == DCW'(FRAC_BITS - 1)) state <= CALC;
        end
        CALC: begin
          pinc_r <= pinc_sat;
          amp_r  <= amp_sat;
          state  <= EMIT;
        end
        EMIT: begin
          m_cfg_tvalid <= 1'b1;
          amp_valid    <= 1'b1;
          m_cfg_tdata  <= {4'b0, pinc_r};
          amp_word     <= amp_r;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/peak_to_dds_cfg.md
Name: peak_to_dds_cfg

Overview:
- Calibration stage directly downstream of the find-max and root-magnitude stages; upstream of the DDS config port and the amplitude multiplier.
- Captures the peak FFT bin index and its two neighbour magnitudes, then refines the frequency with a 3-point centroid offset using a sequential divider.
- Converts the refined frequency to a DDS phase-increment config beat, and the root magnitude to a 16-bit amplitude word.

Parameters:
- DATA_WIDTH, 24, width of the signed peak/neighbour magnitudes
- ADDR_WIDTH, 8, width of the peak bin index
- ROOT_WIDTH, 25, width of the unsigned root magnitude
- FRAC_BITS, 8, fractional bits of the bin offset; also the number of divider iterations
- FREQ_K, 4096, unsigned phase-increment per bin, scaled by 2^FRAC_BITS
- AMP_K, 3, unsigned amplitude gain
- AMP_SHIFT, 2, right shift applied after the amplitude gain
- TIMEOUT_CYCLES, 1024, maximum wait in WAIT_ROOT before abandoning the frame

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- s_peak_tvalid  in  1  peak result valid (single-cycle pulse)
- s_peak_taddr  in  ADDR_WIDTH  peak bin index
- s_peak_tdata_0  in  DATA_WIDTH  signed magnitude of bin taddr-1
- s_peak_tdata_1  in  DATA_WIDTH  signed magnitude of bin taddr
- s_peak_tdata_2  in  DATA_WIDTH  signed magnitude of bin taddr+1
- s_root_tvalid  in  1  root magnitude valid (pulse)
- s_root_tdata  in  ROOT_WIDTH  unsigned root magnitude
- m_cfg_tvalid  out  1  DDS config beat valid (one-cycle pulse)
- m_cfg_tdata  out  32  {4'b0, pinc[27:0]}
- amp_word  out  16  amplitude word (amp = amp_word/2^16), held
- amp_valid  out  1  pulses together with m_cfg_tvalid
- busy  out  1  high whenever state != IDLE
- timeout_err  out  1  one-cycle pulse when a frame is abandoned

Behaviour:
- Reset: state IDLE. m_cfg_tvalid=0, m_cfg_tdata=0, amp_word=0, amp_valid=0, timeout_err=0, busy=0, all internal registers cleared. Reset mid-frame discards the frame; no beat is emitted.
- Input conditioning: negative magnitudes are clamped to 0 on capture.
- IDLE:
  - s_peak_tvalid captures addr and m0/m1/m2, then goes to WAIT_ROOT.
  - If s_root_tvalid is high in the same cycle, the root is also captured and the state goes to DIV.
  - s_root_tvalid alone is ignored.
- WAIT_ROOT:
  - s_root_tvalid captures the root and goes to DIV.
  - A new s_peak_tvalid re-latches the peak data and restarts the timeout counter.
  - Timeout counter reaching TIMEOUT_CYCLES-1 pulses timeout_err and returns to IDLE.
  - If s_peak_tvalid and s_root_tvalid arrive together, the new peak and the root are both captured, then DIV.
- DIV: restoring division of |m2-m0| by den = m0+m1+m2.
  - Exactly FRAC_BITS cycles, one quotient bit per cycle, MSB first.
  - num < den always, so quotient q is in [0, 2^FRAC_BITS).
  - den==0 forces q=0.
  - delta = +q if m2>=m0, else -q.
- CALC (1 cycle):
  - pos = addr*2^FRAC_BITS + delta, signed; pos<0 clamps to 0.
  - pinc = (pos*FREQ_K) >> FRAC_BITS, saturated to 2^28-1.
  - amp = (root*AMP_K) >> AMP_SHIFT, saturated to 65535.
- EMIT (1 cycle):
  - m_cfg_tvalid=1 and amp_valid=1; m_cfg_tdata and amp_word are updated.
  - Next state is IDLE.
  - m_cfg_tdata and amp_word hold until the next EMIT.
- Latency: m_cfg_tvalid is high in the cycle FRAC_BITS+2 edges after the edge that sampled s_root_tvalid (10 with defaults).
- Drops: s_peak_tvalid and s_root_tvalid arriving during DIV, CALC or EMIT are dropped with no side effects.
- Intermediate widths: full precision, no intermediate truncation before saturation.

Test Plan:
- Symmetric peak: addr=10, m0=100, m1=1000, m2=100, then root=5000 3 cycles later -> delta=0, pinc=40960, m_cfg_tdata=0x0000A000, amp_word=3750; tvalid exactly 10 cycles after the root edge, for one cycle.
- Right-leaning peak: addr=10, m0=0, m1=300, m2=100 -> q=64, pinc=41984. Left-leaning peak (m0=100, m2=0) -> pinc=39936.
- Boundaries:
  - addr=0 with m0=100, m1=300, m2=0 -> pos clamps to 0, pinc=0.
  - All magnitudes 0 -> q=0.
  - root=2^24-1 -> amp_word=65535.
  - Negative m1 input is treated as 0.
- Timeout: peak with no root -> timeout_err pulses at cycle 1024 of WAIT_ROOT, no m_cfg_tvalid; busy falls. A root pulse afterwards is ignored.
- Sequencing:
  - Second peak in WAIT_ROOT -> second peak's values are used.
  - Peak and root in the same cycle from IDLE -> output at +10.
  - Peak during DIV -> dropped.
  - rst asserted during DIV -> no beat emitted, outputs 0.
